// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer: alu command codes
// (same values as the mips_16 alu) and the sequencer state encoding.
package alu_mul_seq_pkg;

   localparam logic [2:0] ALU_NC  = 3'd0;
   localparam logic [2:0] ALU_ADD = 3'd1;
   localparam logic [2:0] ALU_SUB = 3'd2;
   localparam logic [2:0] ALU_AND = 3'd3;
   localparam logic [2:0] ALU_OR  = 3'd4;
   localparam logic [2:0] ALU_XOR = 3'd5;
   localparam logic [2:0] ALU_SL  = 3'd6;
   localparam logic [2:0] ALU_SR  = 3'd7;

   typedef enum logic [1:0] {
      MSEQ_IDLE  = 2'b00,
      MSEQ_ADD   = 2'b01,
      MSEQ_SHIFT = 2'b10,
      MSEQ_DONE  = 2'b11
   } mseq_state_e;

endpackage : alu_mul_seq_pkg

// File: rtl/alu_mul_seq.sv
// Multi-cycle 16x16 (low 16 bits) shift-and-add multiplier that borrows the
// pipeline's shared alu for every add and shift.
module alu_mul_seq
   import alu_mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter bit          EARLY_TERM = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             alu_req,
   input  logic             alu_gnt,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_cmd,
   input  logic [WIDTH-1:0] alu_r
);

   localparam int unsigned ITER_W = $clog2(WIDTH + 1);

   mseq_state_e       state_q, state_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              term;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= MSEQ_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         iter_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         iter_q   <= iter_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      iter_d   = iter_q;
      result_d = result_q;
      alu_req  = 1'b0;
      alu_a    = '0;
      alu_b    = '0;
      alu_cmd  = ALU_NC;
      done     = 1'b0;
      busy     = (state_q != MSEQ_IDLE);
      term     = EARLY_TERM ? (mplier_q == '0) : (iter_q == ITER_W'(WIDTH));

      unique case (state_q)
         MSEQ_IDLE: begin
            if (start) begin
               acc_d    = '0;
               mcand_d  = op_a;
               mplier_d = op_b;
               iter_d   = '0;
               state_d  = MSEQ_ADD;
            end
         end
         MSEQ_ADD: begin
            if (term) begin
               state_d = MSEQ_DONE;
            end else if (mplier_q[0]) begin
               alu_req = 1'b1;
               alu_cmd = ALU_ADD;
               alu_a   = acc_q;
               alu_b   = mcand_q;
               if (alu_gnt) begin
                  acc_d   = alu_r;
                  state_d = MSEQ_SHIFT;
               end
            end else begin
               state_d = MSEQ_SHIFT;
            end
         end
         MSEQ_SHIFT: begin
            alu_req = 1'b1;
            alu_cmd = ALU_SL;
            alu_a   = mcand_q;
            alu_b   = WIDTH'(1);
            if (alu_gnt) begin
               mcand_d  = alu_r;
               mplier_d = mplier_q >> 1;
               iter_d   = iter_q + 1'b1;
               state_d  = MSEQ_ADD;
            end
         end
         MSEQ_DONE: begin
            done     = 1'b1;
            result_d = acc_q;
            state_d  = MSEQ_IDLE;
         end
         default: state_d = MSEQ_IDLE;
      endcase

      // Abort overrides every transition and freezes all data registers.
      if (abort) begin
         state_d  = MSEQ_IDLE;
         acc_d    = acc_q;
         mcand_d  = mcand_q;
         mplier_d = mplier_q;
         iter_d   = iter_q;
         result_d = result_q;
      end
   end

   // The product is visible during the done pulse, then held from result_q.
   assign result = (state_q == MSEQ_DONE) ? acc_q : result_q;

endmodule : alu_mul_seq
